// File: rtl/mesm6_mem_arbiter_if.sv
// Core-side (ibus/dbus) and memory-side signals of the mesm6 memory arbiter.
// The arbiter uses the slave modport; the core/memory environment uses the master modport.
interface mesm6_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 48
);
  logic              ibus_fetch;
  logic [ADDR_W-1:0] ibus_addr;
  logic [DATA_W-1:0] ibus_input;
  logic              ibus_done;

  logic              dbus_read;
  logic              dbus_write;
  logic [ADDR_W-1:0] dbus_addr;
  logic [DATA_W-1:0] dbus_output;
  logic [DATA_W-1:0] dbus_input;
  logic              dbus_done;

  logic              mem_valid;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  ibus_fetch, ibus_addr,
    output ibus_input, ibus_done,
    input  dbus_read, dbus_write, dbus_addr, dbus_output,
    output dbus_input, dbus_done,
    output mem_valid, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output ibus_fetch, ibus_addr,
    input  ibus_input, ibus_done,
    output dbus_read, dbus_write, dbus_addr, dbus_output,
    input  dbus_input, dbus_done,
    input  mem_valid, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mesm6_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between the mesm6 ibus and dbus.
// Grant -> done pulse takes 2 cycles plus memory wait cycles; mem_* held until mem_ready.
module mesm6_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 48
) (
  input logic                clk,
  input logic                reset,
  mesm6_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_I,
    S_BUSY_D,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_last_d;
  logic              r_mask_i;
  logic              r_mask_d;
  logic              r_mem_valid;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_ibus_input;
  logic [DATA_W-1:0] r_dbus_input;
  logic              r_ibus_done;
  logic              r_dbus_done;

  logic              w_req_i;
  logic              w_req_d;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_complete;

  // The core still shows a served request for one cycle after its done pulse.
  assign w_req_i = bus.ibus_fetch & ~r_mask_i;
  assign w_req_d = (bus.dbus_read | bus.dbus_write) & ~r_mask_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_i && w_req_d) begin
          w_grant_i = r_last_d;
          w_grant_d = ~r_last_d;
        end else begin
          w_grant_i = w_req_i;
          w_grant_d = w_req_d;
        end
        if (w_grant_i) begin
          w_state_nxt = S_BUSY_I;
        end else if (w_grant_d) begin
          w_state_nxt = S_BUSY_D;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (bus.mem_ready) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d     <= 1'b0;
      r_mask_i     <= 1'b0;
      r_mask_d     <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_ibus_input <= '0;
      r_dbus_input <= '0;
      r_ibus_done  <= 1'b0;
      r_dbus_done  <= 1'b0;
    end else begin
      r_ibus_done <= 1'b0;
      r_dbus_done <= 1'b0;
      // Done is high only in DONE, so this masks exactly the following IDLE cycle.
      r_mask_i    <= r_ibus_done;
      r_mask_d    <= r_dbus_done;

      if (w_grant_i) begin
        r_mem_valid <= 1'b1;
        r_mem_write <= 1'b0;
        r_mem_addr  <= bus.ibus_addr;
        r_last_d    <= 1'b0;
      end

      // A simultaneous read+write from the core is issued as a write.
      if (w_grant_d) begin
        r_mem_valid <= 1'b1;
        r_mem_write <= bus.dbus_write;
        r_mem_addr  <= bus.dbus_addr;
        r_mem_wdata <= bus.dbus_output;
        r_last_d    <= 1'b1;
      end

      if (w_complete) begin
        r_mem_valid <= 1'b0;
        if (r_state == S_BUSY_I) begin
          r_ibus_input <= bus.mem_rdata;
          r_ibus_done  <= 1'b1;
        end else begin
          if (!r_mem_write) begin
            r_dbus_input <= bus.mem_rdata;
          end
          r_dbus_done <= 1'b1;
        end
      end
    end
  end

  assign bus.mem_valid  = r_mem_valid;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.ibus_input = r_ibus_input;
  assign bus.ibus_done  = r_ibus_done;
  assign bus.dbus_input = r_dbus_input;
  assign bus.dbus_done  = r_dbus_done;

endmodule
